spart_core: RTL and testbench

- Serial peripheral (SPART) directly downstream of the bus driver.
- Decodes the driver's iocs/iorw/ioaddr/databus accesses and holds a 16-bit baud divisor.
- Contains an 8N1 transmitter and an 8N1 receiver, both with 16x oversampling, and exposes rda/tbr back to the driver.
- Connects the 8-bit tri-state databus to the txd/rxd pins.

---
 rtl/spart_pkg.sv | 9 +
 rtl/spart_if.sv | 13 +
 rtl/spart_baud_gen.sv | 14 +
 rtl/spart_core.sv | 107 ++++++++++
 tb/tb_spart_core.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/spart_pkg.sv
// spart_pkg: register map, FSM state encoding and oversampling constants shared by the SPART.
package spart_pkg;
    localparam logic [1:0] ADDR_BUF  = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;
    localparam logic [3:0] OVERSAMPLE_MID = 4'd8;
    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_e;
endpackage

// File: rtl/spart_if.sv
// spart_if: driver-side control/status strobes and serial pins of the SPART.
// The 8-bit tri-state databus stays a plain inout port on spart_core.
interface spart_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;
    logic       txd;
    logic       rxd;
    modport master (output iocs, iorw, ioaddr, rxd, input rda, tbr, txd);
    modport slave  (input iocs, iorw, ioaddr, rxd, output rda, tbr, txd);
endinterface

// File: rtl/spart_baud_gen.sv
// spart_baud_gen: down-counter emitting a one-cycle tick every db+1 clocks.
module spart_baud_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] db,
    output logic        tick
);
    logic [15:0] cnt_q;
    assign tick = (cnt_q == 16'd0);
    // db is only sampled on reload, so a divisor write never cuts a period short
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= 16'd0;
        else        cnt_q <= tick ? db : cnt_q - 16'd1;
endmodule

// File: rtl/spart_core.sv
// spart_core: bus-mapped 8N1 UART with 16x oversampled TX/RX and programmable baud divisor.
// Define SPART_OVERRUN_EN to add a sticky receive-overrun flag at status bit 2.
module spart_core import spart_pkg::*; #(
    parameter logic [15:0] DB_RESET   = 16'h0145,
    parameter int          OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    spart_if.slave     bus,
    inout  wire  [7:0] databus
);
    localparam logic [3:0] OS_LAST = 4'(OVERSAMPLE - 1);
    logic        tick, wr, rd, wr_buf, rd_buf, ovr, done;
    logic [15:0] db_q, db_d;
    logic [7:0]  wdata, rd_mux, status, rxbuf_q, rxbuf_d;
    state_e      tx_q, tx_d, rx_q, rx_d;
    logic [3:0]  tcnt_q, tcnt_d, rcnt_q, rcnt_d;
    logic [2:0]  tbit_q, tbit_d, rbit_q, rbit_d;
    logic [7:0]  tsh_q, tsh_d, rsh_q, rsh_d;
    logic        tbr_q, tbr_d, txd_q, txd_d, rda_q, rda_d;
    logic [2:0]  rsync_q;

    spart_baud_gen u_baud (.clk(clk), .rst_n(rst_n), .db(db_q), .tick(tick));

    assign wdata   = databus;
    assign wr      = bus.iocs & ~bus.iorw;
    assign rd      = bus.iocs & bus.iorw;
    assign wr_buf  = wr & (bus.ioaddr == ADDR_BUF);
    assign rd_buf  = rd & (bus.ioaddr == ADDR_BUF);
    assign status  = {5'b0, ovr, tbr_q, rda_q};
    assign rd_mux  = bus.ioaddr[0] ? status : rxbuf_q;
    assign databus = (rd & ~bus.ioaddr[1]) ? rd_mux : 8'hzz;
    assign bus.rda = rda_q;
    assign bus.tbr = tbr_q;
    assign bus.txd = txd_q;

`ifdef SPART_OVERRUN_EN
    logic ovr_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ovr_q <= 1'b0;
        else        ovr_q <= (done & rda_q & ~rd_buf) ? 1'b1 :
                             (rd & (bus.ioaddr == ADDR_STAT)) ? 1'b0 : ovr_q;
    assign ovr = ovr_q;
`else
    assign ovr = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q <= DB_RESET; rxbuf_q <= 8'h00; rda_q <= 1'b0; tbr_q <= 1'b1; txd_q <= 1'b1;
            tx_q <= IDLE; tcnt_q <= '0; tbit_q <= '0; tsh_q <= '0;
            rx_q <= IDLE; rcnt_q <= '0; rbit_q <= '0; rsh_q <= '0; rsync_q <= 3'b111;
        end else begin
            db_q <= db_d; rxbuf_q <= rxbuf_d; rda_q <= rda_d; tbr_q <= tbr_d; txd_q <= txd_d;
            tx_q <= tx_d; tcnt_q <= tcnt_d; tbit_q <= tbit_d; tsh_q <= tsh_d;
            rx_q <= rx_d; rcnt_q <= rcnt_d; rbit_q <= rbit_d; rsh_q <= rsh_d;
            rsync_q <= {rsync_q[1:0], bus.rxd};
        end
    end

    always_comb begin
        db_d    = (wr & (bus.ioaddr == ADDR_DBL)) ? {db_q[15:8], wdata} :
                  (wr & (bus.ioaddr == ADDR_DBH)) ? {wdata, db_q[7:0]} : db_q;
        rda_d   = done | (rda_q & ~rd_buf);
        rxbuf_d = done ? rsh_q : rxbuf_q;
    end

    // tbr is high exactly while idle, so writes during a frame fall through
    always_comb begin
        tx_d = tx_q; tcnt_d = tcnt_q; tbit_d = tbit_q; tsh_d = tsh_q; tbr_d = tbr_q;
        if (tx_q == IDLE) begin
            if (wr_buf) begin tx_d = START; tsh_d = wdata; tbr_d = 1'b0; tcnt_d = '0; end
        end else if (tick) begin
            tcnt_d = tcnt_q + 4'd1;
            if (tcnt_q == OS_LAST)
                case (tx_q)
                    START:   begin tx_d = DATA; tbit_d = '0; end
                    DATA:    begin
                        tsh_d = tsh_q >> 1; tbit_d = tbit_q + 3'd1;
                        if (tbit_q == 3'd7) tx_d = STOP;
                    end
                    default: begin tx_d = IDLE; tbr_d = 1'b1; end
                endcase
        end
        txd_d = (tx_d == START) ? 1'b0 : (tx_d == DATA) ? tsh_d[0] : 1'b1;
    end

    // rsync_q[1] is the synchronized rxd, rsync_q[2] its previous value for edge detect
    always_comb begin
        rx_d = rx_q; rcnt_d = rcnt_q; rbit_d = rbit_q; rsh_d = rsh_q; done = 1'b0;
        if (rx_q == IDLE) begin
            if (!rsync_q[1] && rsync_q[2]) begin rx_d = START; rcnt_d = '0; end
        end else if (tick) begin
            rcnt_d = rcnt_q + 4'd1;
            case (rx_q)
                START: if (rcnt_q == OVERSAMPLE_MID - 4'd1) begin
                    rx_d = rsync_q[1] ? IDLE : DATA; rcnt_d = '0; rbit_d = '0;
                end
                DATA: if (rcnt_q == OS_LAST) begin
                    rsh_d = {rsync_q[1], rsh_q[7:1]}; rbit_d = rbit_q + 3'd1;
                    if (rbit_q == 3'd7) rx_d = STOP;
                end
                default: if (rcnt_q == OS_LAST) begin rx_d = IDLE; done = rsync_q[1]; end
            endcase
        end
    end
endmodule

// File: tb/tb_spart_core.sv
// tb_spart_core: directed bus/serial stimulus for spart_core with hand-computed expectations.
module tb_spart_core;
    import spart_pkg::*;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    wire  [7:0] databus;
    logic [7:0] drv_data = 8'h00;
    logic       drv_en = 1'b0;
    logic [7:0] rd_val;
    logic [9:0] tx_exp;
    int         vectors = 0;
    int         errors = 0;
    int         n;

    spart_if bus ();
    spart_core dut (.clk(clk), .rst_n(rst_n), .bus(bus), .databus(databus));

    assign databus = drv_en ? drv_data : 8'hzz;
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (databus[g]);
    end

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        bus.iocs = 1'b1; bus.iorw = 1'b0; bus.ioaddr = a; drv_data = d; drv_en = 1'b1;
        @(negedge clk);
        bus.iocs = 1'b0; drv_en = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = a;
        #1 d = databus;
        @(negedge clk);
        bus.iocs = 1'b0; bus.iorw = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        bus.rxd = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rxd = b[i];
            repeat (64) @(negedge clk);
        end
        bus.rxd = stop_bit;
        repeat (64) @(negedge clk);
        bus.rxd = 1'b1;
    endtask

    initial begin
        bus.iocs = 1'b0; bus.iorw = 1'b0; bus.ioaddr = 2'b00; bus.rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_txd", 16'(bus.txd), 16'h1);
        check("rst_tbr", 16'(bus.tbr), 16'h1);
        check("rst_rda", 16'(bus.rda), 16'h0);
        check("bus_release_idle", 16'(databus), 16'h00FF);
        bus_read(ADDR_STAT, rd_val);
        check("rst_status", 16'(rd_val), 16'h0002);
        bus_read(ADDR_DBL, rd_val);
        check("read_dbl_ignored", 16'(rd_val), 16'h00FF);

        bus_write(ADDR_DBL, 8'h03);
        bus_write(ADDR_DBH, 8'h00);
        check("db_value", dut.db_q, 16'h0003);
        repeat (400) @(negedge clk);
        n = 0;
        while (!dut.tick && n < 20) begin @(negedge clk); n++; end
        n = 0;
        do begin @(negedge clk); n++; end while (!dut.tick && n < 20);
        check("tick_period", 16'(n), 16'd4);

        bus_write(ADDR_BUF, 8'hA5);
        check("tbr_after_write", 16'(bus.tbr), 16'h0);
        n = 0;
        while (bus.txd && n < 100) begin @(negedge clk); n++; end
        check("tx_start_seen", 16'(bus.txd), 16'h0);
        tx_exp = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 10; k++) begin
            if (k == 4) begin
                bus_write(ADDR_BUF, 8'hFF);
                repeat (63) @(negedge clk);
            end else begin
                repeat (k == 0 ? 32 : 64) @(negedge clk);
            end
            check("tx_bit", 16'(bus.txd), 16'(tx_exp[k]));
            if (k < 9) check("tbr_busy", 16'(bus.tbr), 16'h0);
        end
        repeat (40) @(negedge clk);
        check("tbr_after_frame", 16'(bus.tbr), 16'h1);
        check("txd_idle_after_frame", 16'(bus.txd), 16'h1);

        send_frame(8'h3C, 1'b1);
        check("rda_set", 16'(bus.rda), 16'h1);
        bus_read(ADDR_BUF, rd_val);
        check("rx_data", 16'(rd_val), 16'h003C);
        check("rda_cleared", 16'(bus.rda), 16'h0);

        bus.rxd = 1'b0;
        repeat (20) @(negedge clk);
        bus.rxd = 1'b1;
        repeat (700) @(negedge clk);
        check("glitch_no_rda", 16'(bus.rda), 16'h0);

        send_frame(8'h5A, 1'b0);
        repeat (50) @(negedge clk);
        check("framing_no_rda", 16'(bus.rda), 16'h0);
        bus_read(ADDR_BUF, rd_val);
        check("framing_buf_kept", 16'(rd_val), 16'h003C);

        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (20) @(negedge clk);
`ifdef SPART_OVERRUN_EN
        bus_read(ADDR_STAT, rd_val);
        check("overrun_status", 16'(rd_val), 16'h0007);
        bus_read(ADDR_STAT, rd_val);
        check("overrun_cleared", 16'(rd_val), 16'h0003);
`else
        bus_read(ADDR_STAT, rd_val);
        check("two_frames_status", 16'(rd_val), 16'h0003);
`endif
        bus_read(ADDR_BUF, rd_val);
        check("overwrite_buf", 16'(rd_val), 16'h0022);

        send_frame(8'h81, 1'b1);
        check("rda_before_reset", 16'(bus.rda), 16'h1);
        bus_write(ADDR_BUF, 8'h00);
        repeat (100) @(negedge clk);
        check("tx_mid_frame", 16'(bus.txd), 16'h0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_txd", 16'(bus.txd), 16'h1);
        check("async_rst_tbr", 16'(bus.tbr), 16'h1);
        check("async_rst_rda", 16'(bus.rda), 16'h0);
        check("async_rst_bus", 16'(databus), 16'h00FF);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_read(ADDR_STAT, rd_val);
        check("post_rst_status", 16'(rd_val), 16'h0002);
        bus_read(ADDR_BUF, rd_val);
        check("post_rst_buf", 16'(rd_val), 16'h0000);
        check("post_rst_db", dut.db_q, 16'h0145);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
